// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared FSM type and sizing for the sequential unsigned multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_W_DEF = 32;
  localparam int CNT_W     = $clog2(MUL_W_DEF);

endpackage

// File: rtl/mulu_1iter.sv
// rtl/mulu_1iter.sv - one combinational shift-add step of the unsigned multiplier
module mulu_1iter
  import mul_pkg::*;
#(
  parameter int MUL_W = MUL_W_DEF
) (
  input  logic [2*MUL_W-1:0] acc,
  input  logic [2*MUL_W-1:0] mcand,
  input  logic [MUL_W-1:0]   mplier,
  output logic [2*MUL_W-1:0] next_acc,
  output logic [2*MUL_W-1:0] next_mcand,
  output logic [MUL_W-1:0]   next_mplier
);

  // acc is 2*MUL_W wide, so the sum can never overflow
  assign next_acc    = mplier[0] ? (acc + mcand) : acc;
  assign next_mcand  = mcand << 1;
  assign next_mplier = mplier >> 1;

endmodule

// File: rtl/multiplier_unsigned_seq.sv
// rtl/multiplier_unsigned_seq.sv - radix-2 sequential unsigned multiplier, valid/ready handshake
// Optional build macro: MULU_EARLY_EXIT_EN (finish as soon as the multiplier is exhausted).
module multiplier_unsigned_seq
  import mul_pkg::*;
#(
  parameter int MUL_W = MUL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [MUL_W-1:0]   i_multiplicand,
  input  logic [MUL_W-1:0]   i_multiplier,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*MUL_W-1:0] o_product,
  output logic               o_busy
);

  localparam int CW = (MUL_W == MUL_W_DEF) ? CNT_W : $clog2(MUL_W);
  localparam logic [CW-1:0] LAST = CW'(MUL_W - 1);

  state_t             state;
  logic [2*MUL_W-1:0] acc, mcand, product;
  logic [MUL_W-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               ready_q, busy_q, valid_q;

  logic [2*MUL_W-1:0] next_acc, next_mcand;
  logic [MUL_W-1:0]   next_mplier;
  logic               last_step;

  mulu_1iter #(.MUL_W(MUL_W)) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .next_acc    (next_acc),
    .next_mcand  (next_mcand),
    .next_mplier (next_mplier)
  );

`ifdef MULU_EARLY_EXIT_EN
  // No set bits left in the multiplier means the accumulator is already final
  assign last_step = (cnt == LAST) || (next_mplier == '0);
`else
  assign last_step = (cnt == LAST);
`endif

  // product is a separate register so the visible result only moves at the end of BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            mcand   <= {{MUL_W{1'b0}}, i_multiplicand};
            mplier  <= i_multiplier;
            acc     <= '0;
            cnt     <= '0;
            state   <= BUSY;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          acc    <= next_acc;
          mcand  <= next_mcand;
          mplier <= next_mplier;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            product <= next_acc;
            state   <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready   = ready_q;
  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_product = product;

endmodule

// File: tb/tb_multiplier_unsigned_seq.sv
// tb/tb_multiplier_unsigned_seq.sv - scoreboard bench for multiplier_unsigned_seq
module tb_multiplier_unsigned_seq;

  localparam int W      = 32;
  localparam int N_RAND = 1200;
`ifdef MULU_EARLY_EXIT_EN
  localparam int LAT_B1 = 2;
`else
  localparam int LAT_B1 = 33;
`endif
  localparam int LAT_FULL = 33;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic           i_ready = 1'b0;
  logic [W-1:0]   i_multiplicand = '0;
  logic [W-1:0]   i_multiplier = '0;
  logic           o_ready, o_valid, o_busy;
  logic [2*W-1:0] o_product;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb[$];

  always #5 clk = ~clk;

  multiplier_unsigned_seq #(.MUL_W(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_product      (o_product),
    .o_busy         (o_busy)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair; the accept edge is counted as latency cycle 1.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!o_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!o_ready) begin
      errors++;
      $display("FAIL accept_wait: o_ready=%0b required 1", o_ready);
    end
    i_valid        = 1'b1;
    i_multiplicand = a;
    i_multiplier   = b;
    sb.push_back(64'(a) * 64'(b));
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 200) begin
      tick();
      lat++;
    end
    checks++;
    if (!o_valid) begin
      errors++;
      $display("FAIL wait_valid: o_valid=%0b required 1 within 200 cycles", o_valid);
    end
  endtask

  task automatic handoff();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_product !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b busy=%0b product=%0h required 0 0 0", o_valid, o_busy, o_product);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: o_ready=%0b required 1", o_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [2*W-1:0] exp;
    accept(32'd3, 32'd5);
    wait_valid(lat);
    exp = sb.pop_front();
    checks++;
    if (lat != LAT_FULL) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required %0d", lat, LAT_FULL);
    end
    checks++;
    if (o_product !== exp || exp !== 64'd15) begin
      errors++;
      $display("FAIL basic_product: got %0h required %0h", o_product, exp);
    end
    handoff();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_handoff: ready=%0b valid=%0b required 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_max_stall();
    int lat;
    logic [2*W-1:0] exp;
    logic held = 1'b1;
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat);
    exp = sb.pop_front();
    checks++;
    if (o_product !== 64'hFFFF_FFFE_0000_0001 || o_product !== exp) begin
      errors++;
      $display("FAIL max_product: got %0h required %0h", o_product, 64'hFFFF_FFFE_0000_0001);
    end
    for (int i = 0; i < 10; i++) begin
      i_valid        = $urandom_range(0, 1);
      i_multiplicand = $urandom;
      i_multiplier   = $urandom;
      tick();
      if (o_valid !== 1'b1 || o_product !== 64'hFFFF_FFFE_0000_0001) held = 1'b0;
    end
    i_valid = 1'b0;
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL max_stall_hold: valid=%0b product=%0h required 1 %0h", o_valid, o_product, 64'hFFFF_FFFE_0000_0001);
    end
    handoff();
    checks++;
    if (o_ready !== 1'b1 || o_product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL max_idle_retain: ready=%0b product=%0h required 1 %0h", o_ready, o_product, 64'hFFFF_FFFE_0000_0001);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    logic [2*W-1:0] exp;
    accept(32'd7, 32'd9);
    repeat (11) tick();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midbusy_state: o_busy=%0b required 1", o_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_product !== '0) begin
      errors++;
      $display("FAIL midbusy_reset: busy=%0b valid=%0b product=%0h required 0 0 0", o_busy, o_valid, o_product);
    end
    sb.delete();
    i_valid        = 1'b1;
    i_multiplicand = 32'd2;
    i_multiplier   = 32'd4;
    sb.push_back(64'd8);
    #1 rst_n = 1'b1;
    tick();
    i_valid = 1'b0;
    wait_valid(lat);
    exp = sb.pop_front();
    checks++;
    if (o_product !== exp || lat != LAT_FULL) begin
      errors++;
      $display("FAIL midbusy_new: product=%0h lat=%0d required %0h %0d", o_product, lat, exp, LAT_FULL);
    end
    handoff();
  endtask

  task automatic test_latency_bounds();
    int lat;
    logic [2*W-1:0] exp;
    accept(32'd100, 32'd1);
    wait_valid(lat);
    exp = sb.pop_front();
    checks++;
    if (lat != LAT_B1 || o_product !== exp) begin
      errors++;
      $display("FAIL lat_b1: lat=%0d product=%0h required %0d %0h", lat, o_product, LAT_B1, exp);
    end
    handoff();
    accept(32'd3, 32'h8000_0000);
    wait_valid(lat);
    exp = sb.pop_front();
    checks++;
    if (lat != LAT_FULL || o_product !== exp) begin
      errors++;
      $display("FAIL lat_msb: lat=%0d product=%0h required %0d %0h", lat, o_product, LAT_FULL, exp);
    end
    handoff();
  endtask

  task automatic test_zero();
    int lat;
    logic [2*W-1:0] exp;
    accept(32'd0, 32'd12345);
    wait_valid(lat);
    exp = sb.pop_front();
    checks++;
    if (o_product !== exp || exp !== '0) begin
      errors++;
      $display("FAIL zero_a: got %0h required %0h", o_product, exp);
    end
    handoff();
    accept(32'h0000_DEAD, 32'd9);
    wait_valid(lat);
    void'(sb.pop_front());
    handoff();
    accept(32'h0000_DEAD, 32'd0);
    wait_valid(lat);
    exp = sb.pop_front();
    checks++;
    if (o_product !== exp || exp !== '0) begin
      errors++;
      $display("FAIL zero_b: got %0h required %0h", o_product, exp);
    end
    handoff();
  endtask

  task automatic test_held_valid();
    int lat;
    i_valid        = 1'b1;
    i_ready        = 1'b1;
    i_multiplicand = 32'd6;
    i_multiplier   = 32'd7;
    sb.push_back(64'd42);
    tick();
    i_multiplicand = 32'd1;
    i_multiplier   = 32'd1;
    wait_valid(lat);
    checks++;
    if (o_product !== sb[0] || lat != LAT_FULL) begin
      errors++;
      $display("FAIL held_valid_product: product=%0h lat=%0d required %0h %0d", o_product, lat, sb[0], LAT_FULL);
    end
    void'(sb.pop_front());
    i_valid = 1'b0;
    tick();
    i_ready = 1'b0;
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_product !== 64'd42) begin
      errors++;
      $display("FAIL held_valid_idle: ready=%0b busy=%0b product=%0h required 1 0 2a", o_ready, o_busy, o_product);
    end
  endtask

  task automatic test_random();
    int lat;
    logic both = 1'b0;
    logic [2*W-1:0] exp;
    logic [W-1:0] a, b;
    for (int i = 0; i < N_RAND; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 8 == 1) a = a & 32'h0000_00FF;
      if (i % 8 == 2) b = b & 32'h0000_000F;
      if (i % 16 == 3) b = 32'hFFFF_FFFF;
      repeat ($urandom_range(0, 2)) begin
        if (o_ready && o_valid) both = 1'b1;
        tick();
      end
      accept(a, b);
      lat = 1;
      while (!o_valid && lat < 200) begin
        i_valid        = $urandom_range(0, 1);
        i_multiplicand = $urandom;
        i_multiplier   = $urandom;
        i_ready        = $urandom_range(0, 1);
        if (o_ready && o_valid) both = 1'b1;
        tick();
        lat++;
      end
      i_valid = 1'b0;
      i_ready = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        if (o_ready && o_valid) both = 1'b1;
        tick();
      end
      exp = sb.pop_front();
      checks++;
      if (o_valid !== 1'b1 || o_product !== exp) begin
        errors++;
        $display("FAIL random_%0d: a=%0h b=%0h valid=%0b product=%0h required %0h", i, a, b, o_valid, o_product, exp);
      end
      handoff();
    end
    checks++;
    if (both) begin
      errors++;
      $display("FAIL ready_valid_exclusive: both high observed=%0b required 0", both);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_stall();
    test_reset_mid_busy();
    test_latency_bounds();
    test_zero();
    test_held_valid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
